// File: rtl/miriscv_mdu_pkg.sv
// Shared types, constants and opcode helpers for the miriscv iterative MDU.
package miriscv_mdu_pkg;

  localparam int unsigned MDU_XLEN  = 32;
  localparam int unsigned MDU_CNT_W = 5;

  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_t;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // Multiply ops returning the upper product word.
  function automatic logic is_high(input logic [2:0] op);
    return (op != MDU_MUL) && !op[2];
  endfunction

  // Divide ops returning the remainder.
  function automatic logic rem_sel(input logic [2:0] op);
    return op[2] && op[1];
  endfunction

  // rs1 signed for MULH, MULHSU, DIV, REM.
  function automatic logic a_signed(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  // rs2 signed for MULH, DIV, REM.
  function automatic logic b_signed(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/miriscv_mdu_abs.sv
// Conditional two's-complement negate.
//   value_i  : W-bit input
//   neg_i    : negate when high
//   result_o : neg_i ? -value_i : value_i
module miriscv_mdu_abs #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] value_i,
  input  logic         neg_i,
  output logic [W-1:0] result_o
);

  assign result_o = neg_i ? (~value_i + W'(1)) : value_i;

endmodule

// File: rtl/miriscv_mdu_iter.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with a final sign fix-up.
//   clk_i, arstn_i       : clock, async active-low reset
//   mdu_req_i/kill_i     : request (sampled in IDLE), flush
//   mdu_op_i             : MUL..REMU opcode
//   mdu_port_a/b_i       : rs1 / rs2 operands
//   mdu_busy_o           : high while not IDLE
//   mdu_valid_o          : one-cycle result strobe
//   mdu_result_o         : result, zero unless mdu_valid_o
module miriscv_mdu_iter
  import miriscv_mdu_pkg::*;
#(
  parameter int unsigned XLEN  = MDU_XLEN,
  parameter int unsigned CNT_W = MDU_CNT_W
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic            mdu_req_i,
  input  logic            mdu_kill_i,
  input  logic [2:0]      mdu_op_i,
  input  logic [XLEN-1:0] mdu_port_a_i,
  input  logic [XLEN-1:0] mdu_port_b_i,
  output logic            mdu_busy_o,
  output logic            mdu_valid_o,
  output logic [XLEN-1:0] mdu_result_o
);

  mdu_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  // Multiply: {partial sum, multiplier}; divide: {remainder, dividend/quotient}.
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic                special_q, special_d;

  logic                a_neg, b_neg, neg_in;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                b_zero, ovf, special_in;
  logic [XLEN-1:0]     special_res;

  assign a_neg = a_signed(mdu_op_i) && mdu_port_a_i[XLEN-1];
  assign b_neg = b_signed(mdu_op_i) && mdu_port_b_i[XLEN-1];

  miriscv_mdu_abs #(.W(XLEN)) u_abs_a (.value_i(mdu_port_a_i), .neg_i(a_neg), .result_o(a_mag));
  miriscv_mdu_abs #(.W(XLEN)) u_abs_b (.value_i(mdu_port_b_i), .neg_i(b_neg), .result_o(b_mag));

  // MUL is computed unsigned; remainder takes the dividend's sign only.
  always_comb begin
    neg_in = a_neg ^ b_neg;
    if (mdu_op_i == MDU_MUL) neg_in = 1'b0;
    else if (rem_sel(mdu_op_i)) neg_in = a_neg;
  end

  assign b_zero = (mdu_port_b_i == '0);
  assign ovf    = is_div(mdu_op_i) && !mdu_op_i[0]
                  && (mdu_port_a_i == {1'b1, {(XLEN-1){1'b0}}})
                  && (mdu_port_b_i == '1);
  assign special_in = is_div(mdu_op_i) && (b_zero || ovf);

  always_comb begin
    if (b_zero) special_res = rem_sel(mdu_op_i) ? mdu_port_a_i : '1;
    else        special_res = rem_sel(mdu_op_i) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // One shift-add step: add multiplicand into the upper half when the
  // multiplier LSB is set, then shift the whole register right.
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_step;
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_step = {mul_sum, acc_q[XLEN-1:1]};

  // One restoring step: shift in the next dividend bit, keep the difference
  // only when it does not borrow.
  logic [XLEN:0]       rem_sh;
  logic                rem_ge;
  logic [XLEN-1:0]     rem_new;
  logic [2*XLEN-1:0]   div_step;
  assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
  assign rem_ge   = (rem_sh >= {1'b0, b_q});
  assign rem_new  = rem_ge ? (rem_sh[XLEN-1:0] - b_q) : rem_sh[XLEN-1:0];
  assign div_step = {rem_new, acc_q[XLEN-2:0], rem_ge};

  // Divide results are zero-extended so one wide negator serves both units.
  logic [2*XLEN-1:0]   fix_in, fix_out;
  logic [XLEN-1:0]     final_res;
  assign fix_in = is_div(op_q)
                  ? {{XLEN{1'b0}}, (rem_sel(op_q) ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0])}
                  : acc_q;

  miriscv_mdu_abs #(.W(2*XLEN)) u_abs_res (.value_i(fix_in), .neg_i(neg_q), .result_o(fix_out));

  always_comb begin
    if (special_q)         final_res = acc_q[XLEN-1:0];
    else if (is_high(op_q)) final_res = fix_out[2*XLEN-1:XLEN];
    else                   final_res = fix_out[XLEN-1:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    op_d      = op_q;
    neg_d     = neg_q;
    special_d = special_q;
    case (state_q)
      MDU_IDLE: begin
        if (mdu_req_i && !mdu_kill_i) begin
          op_d      = mdu_op_i;
          neg_d     = neg_in;
          b_d       = b_mag;
          special_d = special_in;
          if (special_in) begin
            cnt_d   = '0;
            acc_d   = {{XLEN{1'b0}}, special_res};
            state_d = MDU_DONE;
          end else begin
            cnt_d   = CNT_W'(XLEN - 1);
            acc_d   = {{XLEN{1'b0}}, a_mag};
            state_d = MDU_CALC;
          end
        end
      end
      MDU_CALC: begin
        acc_d = is_div(op_q) ? div_step : mul_step;
        if (cnt_q == '0) state_d = MDU_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      MDU_DONE: state_d = MDU_IDLE;
      default:  state_d = MDU_IDLE;
    endcase
    if (mdu_kill_i) state_d = MDU_IDLE;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q   <= MDU_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      special_q <= special_d;
    end
  end

  assign mdu_busy_o   = (state_q != MDU_IDLE);
  assign mdu_valid_o  = (state_q == MDU_DONE) && !mdu_kill_i;
  assign mdu_result_o = mdu_valid_o ? final_res : '0;

endmodule

// File: tb/tb_miriscv_mdu_iter.sv
module tb_miriscv_mdu_iter;

  logic        clk_i = 1'b0;
  logic        arstn_i = 1'b0;
  logic        mdu_req_i = 1'b0;
  logic        mdu_kill_i = 1'b0;
  logic [2:0]  mdu_op_i = 3'd0;
  logic [31:0] mdu_port_a_i = '0;
  logic [31:0] mdu_port_b_i = '0;
  logic        mdu_busy_o;
  logic        mdu_valid_o;
  logic [31:0] mdu_result_o;

  int n_checks = 0;
  int n_fails  = 0;

  miriscv_mdu_iter dut (
    .clk_i        (clk_i),
    .arstn_i      (arstn_i),
    .mdu_req_i    (mdu_req_i),
    .mdu_kill_i   (mdu_kill_i),
    .mdu_op_i     (mdu_op_i),
    .mdu_port_a_i (mdu_port_a_i),
    .mdu_port_b_i (mdu_port_b_i),
    .mdu_busy_o   (mdu_busy_o),
    .mdu_valid_o  (mdu_valid_o),
    .mdu_result_o (mdu_result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle (cycle 0), leaving the bench at the
  // negedge of cycle 1 with req dropped and operands scrambled.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_i);
    mdu_req_i = 1'b1; mdu_op_i = op; mdu_port_a_i = a; mdu_port_b_i = b;
    @(negedge clk_i);
    mdu_req_i = 1'b0; mdu_port_a_i = $urandom; mdu_port_b_i = $urandom;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat = 0;
    int busy_cnt = 0;
    logic [31:0] res = '0;
    issue(op, a, b);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc > 1) @(negedge clk_i);
      if (mdu_busy_o) busy_cnt++;
      if (mdu_valid_o) begin
        lat = cyc;
        res = mdu_result_o;
        break;
      end
    end
    check_eq({tag, " result"}, res, exp_res);
    check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat));
    @(negedge clk_i);
    check_eq({tag, " idle after"}, {30'd0, mdu_busy_o, mdu_valid_o}, 32'd0);
  endtask

  initial begin
    int vcount;
    #2;
    check_eq("reset busy", {31'd0, mdu_busy_o}, 32'd0);
    check_eq("reset valid", {31'd0, mdu_valid_o}, 32'd0);
    check_eq("reset result", mdu_result_o, 32'd0);
    @(negedge clk_i);
    arstn_i = 1'b1;

    run_op("MUL 7*-3",        3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("MULH min*min",    3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op("MULHU ff*ff",     3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("MULHSU ff*ff",    3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    run_op("DIV -7/2",        3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_op("REM -7/2",        3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op("DIVU 100/7",      3'd5, 32'd100,      32'd7,        32'd14,       33);
    run_op("REMU 100/7",      3'd7, 32'd100,      32'd7,        32'd2,        33);
    run_op("DIV 100/-7",      3'd4, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33);
    run_op("REM 100/-7",      3'd6, 32'd100,      32'hFFFFFFF9, 32'd2,        33);
    run_op("DIVU 5/0",        3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("REM 5/0",         3'd6, 32'd5,        32'd0,        32'd5,        1);
    run_op("DIV ovf",         3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("REM ovf",         3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    // Kill in cycle 10 of a DIV.
    issue(3'd4, 32'd1000, 32'd3);
    for (int cyc = 2; cyc <= 10; cyc++) @(negedge clk_i);
    mdu_kill_i = 1'b1;
    @(negedge clk_i);
    mdu_kill_i = 1'b0;
    check_eq("kill busy low", {31'd0, mdu_busy_o}, 32'd0);
    vcount = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk_i);
      if (mdu_valid_o) vcount++;
    end
    check_eq("kill no valid", 32'(vcount), 32'd0);
    run_op("REMU 9/4", 3'd7, 32'd9, 32'd4, 32'd1, 33);

    // Kill on the DONE cycle suppresses the strobe combinationally.
    issue(3'd5, 32'd100, 32'd7);
    for (int cyc = 2; cyc <= 33; cyc++) @(negedge clk_i);
    check_eq("done busy", {31'd0, mdu_busy_o}, 32'd1);
    mdu_kill_i = 1'b1;
    #1;
    check_eq("done kill valid", {31'd0, mdu_valid_o}, 32'd0);
    check_eq("done kill result", mdu_result_o, 32'd0);
    @(negedge clk_i);
    mdu_kill_i = 1'b0;
    check_eq("done kill idle", {31'd0, mdu_busy_o}, 32'd0);

    // Reset mid-CALC.
    issue(3'd0, 32'd12345, 32'd678);
    for (int cyc = 2; cyc <= 15; cyc++) @(negedge clk_i);
    arstn_i = 1'b0;
    #1;
    check_eq("rst busy", {31'd0, mdu_busy_o}, 32'd0);
    check_eq("rst valid", {31'd0, mdu_valid_o}, 32'd0);
    check_eq("rst result", mdu_result_o, 32'd0);
    @(negedge clk_i);
    arstn_i = 1'b1;
    vcount = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk_i);
      if (mdu_valid_o || mdu_busy_o) vcount++;
    end
    check_eq("rst no residual", 32'(vcount), 32'd0);

    // kill+req together in IDLE: not accepted.
    mdu_req_i = 1'b1; mdu_kill_i = 1'b1; mdu_op_i = 3'd5;
    mdu_port_a_i = 32'd9; mdu_port_b_i = 32'd4;
    @(negedge clk_i);
    mdu_req_i = 1'b0; mdu_kill_i = 1'b0;
    check_eq("kill+req busy", {31'd0, mdu_busy_o}, 32'd0);
    @(negedge clk_i);
    check_eq("kill+req valid", {31'd0, mdu_valid_o}, 32'd0);

    run_op("MUL after", 3'd0, 32'd6, 32'd7, 32'd42, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/miriscv_mdu_iter.md
Name: miriscv_mdu_iter

Overview:
Iterative multiply/divide unit for the miriscv execute stage. It consumes the MDU opcode encoding (MUL..REMU, 3-bit) and returns one 32-bit result per accepted request.
- Multiply: radix-2 shift-add on operand magnitudes.
- Divide: restoring divide on operand magnitudes.
- Final sign fix-up is applied to both.
The core holds its pipeline while mdu_busy_o is high.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
CNT_W, 5, iteration counter width (log2 XLEN)

Ports:
clk_i  in  1  clock
arstn_i  in  1  asynchronous active-low reset
mdu_req_i  in  1  request; sampled only in IDLE
mdu_kill_i  in  1  flush; aborts any in-flight op
mdu_op_i  in  3  opcode: MUL=0 MULH=1 MULHSU=2 MULHU=3 DIV=4 DIVU=5 REM=6 REMU=7
mdu_port_a_i  in  XLEN  rs1 operand
mdu_port_b_i  in  XLEN  rs2 operand
mdu_busy_o  out  1  high whenever state != IDLE
mdu_valid_o  out  1  one-cycle result strobe
mdu_result_o  out  XLEN  result; valid only while mdu_valid_o=1, otherwise 0

Behaviour:
- Reset (arstn_i=0, async): state=IDLE, counter=0, all datapath registers=0, busy/valid/result=0.
- States:
  - IDLE: on req & ~kill, latch op, sign flags, |a|, |b|. Special case goes to DONE; else CALC with counter=XLEN-1.
  - CALC: one iteration per clock; counter decrements; at counter==0 go to DONE.
  - DONE: valid_o=1 with the fixed-up result; next state IDLE.
- Latency, counting the accept cycle as 0:
  - Normal ops: valid_o in cycle 33, so throughput is one op per 34 cycles.
  - Special cases: valid_o in cycle 1.
- Sign rules:
  - a is signed for MULH, MULHSU, DIV, REM; b is signed for MULH, DIV, REM.
  - MUL result does not depend on signedness; it is computed unsigned.
  - Magnitude = two's-complement negate when a signed operand has MSB set.
- Multiply: 64-bit unsigned product of magnitudes, negated if exactly one used operand is negative. MUL returns [31:0]; MULH/MULHSU/MULHU return [63:32].
- Divide: unsigned restoring divide, 32 iterations, each producing one quotient bit (shift remainder, trial subtract, restore on borrow).
  - Quotient negated if signed op and signs differ.
  - Remainder negated if signed op and a negative.
- Special cases, detected at accept with no iterations:
  - b==0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give a.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- Kill:
  - In any state, next state is IDLE and no valid_o is produced.
  - kill in DONE suppresses that cycle's valid_o combinationally.
  - kill with req in IDLE: kill wins and the request is not accepted.
- req while busy: ignored. The core must re-present the request only after completion.
- Operand changes after accept have no effect, since operands are latched.
- Reset mid-operation: immediate return to reset values; no residual valid.

Decomposition:
- Additions to miriscv_mdu_pkg:
  - MDU_XLEN, MDU_CNT_W.
  - State enum type mdu_state_t {MDU_IDLE, MDU_CALC, MDU_DONE}.
  - Helper predicates: is_div(op) = op[2]; is_high(op) = (op != MDU_MUL) & ~op[2]; rem_sel = op[1] when op[2].
- One natural sub-module, miriscv_mdu_abs: combinational conditional two's-complement (value, negate enable). It is instantiated for both operand magnitudes and for result fix-up.
- Multiplier and divider share the 64-bit accumulator/shift register and the counter.

Test Plan:
- MUL a=7 b=0xFFFFFFFD -> result 0xFFFFFFEB; valid_o in cycle 33; busy_o high cycles 1..33.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each with valid_o in cycle 1. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 with valid_o in cycle 1.
- Kill in cycle 10 of a DIV -> busy_o low next cycle, no valid_o. A following REMU 9/4 is accepted and returns 1 after 33 cycles.
- arstn_i pulsed low mid-CALC -> all outputs 0 immediately. kill+req together in IDLE -> no accept, busy_o stays 0.
